// File: rtl/counter_chip_p_if.sv
// Control/data bundle for counter_chip_p.
// The master side drives the controls and load data; the slave (counter) returns q and rco.
interface counter_chip_p_if #(
    parameter int unsigned WIDTH = 4
);
    logic             clr_n;
    logic             load_n;
    logic             enp;
    logic             ent;
    logic             up;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             rco;

    modport master (
        output clr_n, load_n, enp, ent, up, d,
        input  q, rco
    );

    modport slave (
        input  clr_n, load_n, enp, ent, up, d,
        output q, rco
    );
endinterface

// File: rtl/counter_chip_p.sv
// Parametrised synchronous counter (74HC160/161/163 style) with synchronous clear,
// parallel load, cascadable enables and combinational ripple-carry output.
// Optional feature macro: COUNTER_DOWN_EN enables up/down counting (74HC191 style).
// Without it the up input is ignored and the counter only counts up.
module counter_chip_p #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input logic              clk,
    input logic              reset,
    counter_chip_p_if.slave  bus
);

    // Reject illegal parameterisations at elaboration time.
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("counter_chip_p: WIDTH must be within 1..16");
    end
    if (MODULUS < 2) begin : g_bad_mod_low
        $error("counter_chip_p: MODULUS must be at least 2");
    end
    if (MODULUS > (32'd1 << WIDTH)) begin : g_bad_mod_high
        $error("counter_chip_p: MODULUS must not exceed 2**WIDTH");
    end

    // MODULUS-1 always fits in WIDTH bits, so every comparison stays WIDTH wide.
    localparam logic [WIDTH-1:0] TopVal  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZeroVal = '0;
    localparam logic [WIDTH-1:0] OneVal  = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] up_next;
    logic             count_en;
    logic             at_top_or_beyond;
    logic [WIDTH-1:0] terminal;

    assign count_en         = bus.enp & bus.ent;
    assign at_top_or_beyond = (count_q >= TopVal);

    // Up step: compare before adding so the sum never needs a carry bit.
    always_comb begin
        up_next = ZeroVal;
        if (!at_top_or_beyond) begin
            up_next = count_q + OneVal;
        end
    end

`ifdef COUNTER_DOWN_EN
    logic [WIDTH-1:0] down_next;

    // Down step: zero and out-of-range states both reload the top value.
    always_comb begin
        down_next = TopVal;
        if (count_q != ZeroVal && count_q <= TopVal) begin
            down_next = count_q - OneVal;
        end
    end

    // Terminal value depends on direction.
    always_comb begin
        terminal = bus.up ? TopVal : ZeroVal;
    end

    // Next-state selection: reset > clear > load > count > hold.
    always_comb begin
        count_d = count_q;
        if (reset) begin
            count_d = ZeroVal;
        end else if (!bus.clr_n) begin
            count_d = ZeroVal;
        end else if (!bus.load_n) begin
            count_d = bus.d;
        end else if (count_en) begin
            count_d = bus.up ? up_next : down_next;
        end
    end
`else
    // Direction input is accepted but has no effect in the up-only build.
    logic unused_up;
    assign unused_up = bus.up;

    // Up-only build has a single fixed terminal value.
    always_comb begin
        terminal = TopVal;
    end

    // Next-state selection: reset > clear > load > count > hold.
    always_comb begin
        count_d = count_q;
        if (reset) begin
            count_d = ZeroVal;
        end else if (!bus.clr_n) begin
            count_d = ZeroVal;
        end else if (!bus.load_n) begin
            count_d = bus.d;
        end else if (count_en) begin
            count_d = up_next;
        end
    end
`endif

    // Counter state register; reset is folded into count_d as a synchronous term.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign bus.q = count_q;

    // Ripple carry is purely combinational so cascaded stages advance with no added latency.
    assign bus.rco = bus.ent & (count_q == terminal);

endmodule
